// File: rtl/io_rx_pkg.sv
// =============================================================================
// io_rx_pkg : shared constants and types for the IO port receiver
// Rev 1.0
// =============================================================================
`default_nettype none

package io_rx_pkg;

    localparam int   IO_RX_DATA_WIDTH    = 8;
    localparam int   IO_RX_DEFAULT_DEPTH = 16;
    // Write strobe is active-low, so "no write in progress" reads as 1.
    localparam logic IO_RX_STROBE_IDLE   = 1'b1;

    typedef logic [7:0] io_byte_t;

endpackage : io_rx_pkg

`default_nettype wire

// File: rtl/io_port_rx_sync_fifo.sv
// =============================================================================
// sync_fifo : show-ahead synchronous FIFO, count-based full/empty
// Rev 1.0
// =============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int PTR_WIDTH  = $clog2(DEPTH),
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  push_ok_o,
    output logic                  pop_ok_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
    assign count_o = count_q;
    // Storage is not reset, so the head is masked to zero while empty.
    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        pop_ok_o  = pop_i & ~empty_o;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push_ok_o = push_i & (~full_o | pop_ok_o);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (push_ok_o) wptr_d = wptr_q + PTR_WIDTH'(1);
        if (pop_ok_o)  rptr_d = rptr_q + PTR_WIDTH'(1);
        count_d = count_q + CNT_WIDTH'(push_ok_o) - CNT_WIDTH'(pop_ok_o);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wptr_q] <= push_data_i;
    end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/io_port_rx.sv
// =============================================================================
// io_port_rx : captures one byte per CPU write strobe into a FIFO for a
//              valid/ready consumer. IO_RX_STATS_EN adds accept/drop counters.
// Rev 1.0
// =============================================================================
`default_nettype none

module io_port_rx
    import io_rx_pkg::*;
#(
    parameter  int DATA_WIDTH = IO_RX_DATA_WIDTH,
    parameter  int DEPTH      = IO_RX_DEFAULT_DEPTH,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  io_wr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
`ifdef IO_RX_STATS_EN
    output logic [15:0]           rx_total_o,
    output logic [7:0]            drop_total_o,
`endif
    input  logic                  ovf_clr_i
);

    logic wr_q, wr_d;
    logic ovf_q, ovf_d;
    logic push_req, pop, accept, drop;
    logic pop_ok;

    // Only the first low cycle of a strobe counts, however long it is held.
    assign push_req = ~io_wr_i & wr_q;
    assign pop      = rd_valid_o & rd_ready_i;
    assign drop     = push_req & ~accept;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_req),
        .push_data_i (data_i),
        .pop_i       (pop),
        .rd_data_o   (rd_data_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .push_ok_o   (accept),
        .pop_ok_o    (pop_ok)
    );

    assign rd_valid_o = ~empty_o;
    assign overflow_o = ovf_q;

    always_comb begin
        wr_d  = io_wr_i;
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        // A new drop outranks a clear issued in the same cycle.
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_q  <= IO_RX_STROBE_IDLE;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef IO_RX_STATS_EN
    logic [15:0] rx_total_q, rx_total_d;
    logic [7:0]  drop_total_q, drop_total_d;

    always_comb begin
        rx_total_d   = rx_total_q;
        drop_total_d = drop_total_q;
        if (accept) rx_total_d = rx_total_q + 16'd1;
        if (drop && (drop_total_q != 8'hFF)) drop_total_d = drop_total_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_total_q   <= '0;
            drop_total_q <= '0;
        end else begin
            rx_total_q   <= rx_total_d;
            drop_total_q <= drop_total_d;
        end
    end

    assign rx_total_o   = rx_total_q;
    assign drop_total_o = drop_total_q;
`endif

    // pop_ok mirrors pop since rd_valid already gates it; kept for clarity.
    logic unused_pop_ok;
    assign unused_pop_ok = pop_ok;

endmodule : io_port_rx

`default_nettype wire

// File: tb/tb_io_port_rx.sv
// =============================================================================
// tb_io_port_rx : randomized self-checking bench against a queue-based model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_io_port_rx;
    import io_rx_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [DW-1:0] data_i;
    logic          io_wr_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          ovf_clr_i;
`ifdef IO_RX_STATS_EN
    logic [15:0]   rx_total_o;
    logic [7:0]    drop_total_o;
`endif

    io_port_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .io_wr_i      (io_wr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
`ifdef IO_RX_STATS_EN
        .rx_total_o   (rx_total_o),
        .drop_total_o (drop_total_o),
`endif
        .ovf_clr_i    (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain byte queue plus flags.
    logic [7:0] m_q[$];
    bit         m_prev_wr;
    bit         m_ovf;
    int         m_rx;
    int         m_drop;

    logic [7:0] sent[$];
    logic [7:0] obs[$];
    bit         rec_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev_wr = 1'b1;
        m_ovf     = 1'b0;
        m_rx      = 0;
        m_drop    = 0;
    endtask

    task automatic model_update();
        bit strobe, popping;
        strobe  = !io_wr_i && m_prev_wr;
        popping = (m_q.size() > 0) && rd_ready_i;
        if (popping) void'(m_q.pop_front());
        if (ovf_clr_i) m_ovf = 1'b0;
        if (strobe) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(data_i);
                m_rx = (m_rx + 1) & 32'hFFFF;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_prev_wr = io_wr_i;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 8'h00;
        chk({tag, "_valid"}, rd_valid_o, m_q.size() > 0);
        chk({tag, "_data"},  rd_data_o,  head);
        chk({tag, "_count"}, count_o,    m_q.size());
        chk({tag, "_full"},  full_o,     m_q.size() == DEPTH);
        chk({tag, "_empty"}, empty_o,    m_q.size() == 0);
        chk({tag, "_ovf"},   overflow_o, m_ovf);
`ifdef IO_RX_STATS_EN
        chk({tag, "_rxtot"}, rx_total_o,   m_rx);
        chk({tag, "_drop"},  drop_total_o, m_drop);
`endif
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            if (rec_en && rd_valid_o && rd_ready_i) obs.push_back(rd_data_o);
            @(posedge clk_i);
            model_update();
            @(negedge clk_i);
            check_all("cyc");
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        io_wr_i = 1'b0;
        data_i  = d;
        step(1);
        io_wr_i = 1'b1;
        data_i  = 8'($urandom);
        step(1);
    endtask

    initial begin
        reset_i    = 1'b0;
        io_wr_i    = 1'b1;
        data_i     = '0;
        rd_ready_i = 1'b0;
        ovf_clr_i  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all("reset");
        reset_i = 1'b1;

        // Single short strobe
        pulse(8'h41);
        chk("t1_data", rd_data_o, 8'h41);
        chk("t1_count", count_o, 1);
        rd_ready_i = 1'b1;
        step(1);
        rd_ready_i = 1'b0;

        // Strobe held low for 5 cycles captures once
        io_wr_i = 1'b0;
        data_i  = 8'h55;
        step(5);
        io_wr_i = 1'b1;
        step(1);
        chk("t2_count", count_o, 1);
        rd_ready_i = 1'b1;
        step(1);
        rd_ready_i = 1'b0;

        // Fill, overflow, set-beats-clear, then drain in order
        for (int i = 0; i < 16; i++) pulse(8'(i));
        chk("t3_full", full_o, 1);
        pulse(8'hAA);
        chk("t3_ovf", overflow_o, 1);
        chk("t3_count", count_o, 16);
        io_wr_i   = 1'b0;
        data_i    = 8'hAB;
        ovf_clr_i = 1'b1;
        step(1);
        io_wr_i   = 1'b1;
        ovf_clr_i = 1'b0;
        step(1);
        chk("t3_setwins", overflow_o, 1);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", rd_data_o, 8'(i));
            step(1);
        end
        rd_ready_i = 1'b0;
        chk("t3_empty", empty_o, 1);
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;

        // Push into a full FIFO while the head pops
        for (int i = 0; i < 16; i++) pulse(8'(8'h10 + i));
        rd_ready_i = 1'b1;
        io_wr_i    = 1'b0;
        data_i     = 8'h77;
        step(1);
        rd_ready_i = 1'b0;
        io_wr_i    = 1'b1;
        step(1);
        chk("t4_count", count_o, 16);
        chk("t4_ovf", overflow_o, 0);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain", rd_data_o, (i < 15) ? 8'(8'h11 + i) : 8'h77);
            step(1);
        end

        // Interleaved traffic wrapping the pointers twice
        rec_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            sent.push_back(d);
            pulse(d);
        end
        step(2);
        rec_en = 1'b0;
        chk("t5_nobs", obs.size(), 40);
        for (int i = 0; i < 40 && i < obs.size(); i++) chk("t5_order", obs[i], sent[i]);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            io_wr_i    = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            data_i     = 8'($urandom);
            rd_ready_i = ($urandom_range(0, 9) < 3);
            ovf_clr_i  = ($urandom_range(0, 19) == 0);
            step(1);
        end
        io_wr_i   = 1'b1;
        ovf_clr_i = 1'b1;
        rd_ready_i = 1'b0;
        step(1);
        ovf_clr_i = 1'b0;
        chk("t6_ovfclr", overflow_o, 0);

        // Reset mid-operation with 3 entries buffered
        while (count_o != 0 && n_cmp < 200000) begin
            rd_ready_i = 1'b1;
            step(1);
        end
        rd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'(8'hC0 + i));
        chk("t7_pre", count_o, 3);
        reset_i = 1'b0;
        #1;
        chk("t7_empty", empty_o, 1);
        chk("t7_valid", rd_valid_o, 0);
        chk("t7_count", count_o, 0);
`ifdef IO_RX_STATS_EN
        chk("t7_rxtot", rx_total_o, 0);
`endif
        model_reset();
        @(negedge clk_i);
        // Strobe already low at release is captured once
        io_wr_i = 1'b0;
        data_i  = 8'h3C;
        reset_i = 1'b1;
        step(3);
        io_wr_i = 1'b1;
        step(1);
        chk("t7_rel_count", count_o, 1);
        chk("t7_rel_data", rd_data_o, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_io_port_rx

`default_nettype wire
